// File: rtl/instr_feeder.sv
// instr_feeder: program store plus sequencer that feeds 16-bit instruction
// words to a processor one at a time.
//
// Software loads the program memory while the block is not busy, then pulses
// start. Words are fetched from address 0 upward. Each word is held on iin
// until the processor raises instr_done, at which point bus is captured into
// result and the next word is fetched. Execution stops on HALT_WORD (never
// issued), after the last memory word (no wrap), or on a completion timeout.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   load_en/addr/data     program write, honoured only while busy=0
//   start                 run from address 0, honoured only while busy=0
//   instr_done, bus       processor completion strobe and result bus
//   iin, iin_valid        instruction word to the processor and its qualifier
//   pc                    address of the current/next instruction
//   result                last captured bus value
//   busy, halted, fault   registered one-hot state flags
module instr_feeder #(
  parameter int          ADDR_W    = 6,
  parameter logic [15:0] HALT_WORD = 16'hFFFF,
  parameter int          TIMEOUT   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [15:0]       load_data,
  input  logic              start,
  input  logic              instr_done,
  input  logic [15:0]       bus,
  output logic [15:0]       iin,
  output logic              iin_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       result,
  output logic              busy,
  output logic              halted,
  output logic              fault
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam int              TW      = $clog2(TIMEOUT);
  localparam logic [ADDR_W-1:0] PC_LAST = '1;
  localparam logic [TW-1:0]   T_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CHECK, S_ISSUE, S_HALT, S_FAULT
  } state_t;

  state_t            state, state_nxt;
  logic [15:0]       mem [0:DEPTH-1];
  logic [15:0]       rdata;
  logic [TW-1:0]     timer, timer_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [15:0]       iin_nxt, result_nxt;
  logic              valid_nxt;
  logic              idle_like;

  // Memory may only be touched by software when no program is running, so
  // the write and the FETCH read can never collide.
  assign idle_like = (state == S_IDLE) || (state == S_HALT) || (state == S_FAULT);

  // Program memory is deliberately outside reset so a loaded program
  // survives a reset and can be rerun.
  always_ff @(posedge clock) begin
    if (idle_like && load_en) mem[load_addr] <= load_data;
    if (state == S_FETCH)     rdata <= mem[pc];
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    iin_nxt    = iin;
    valid_nxt  = iin_valid;
    result_nxt = result;
    timer_nxt  = timer;
    case (state)
      S_IDLE, S_HALT, S_FAULT: begin
        if (start) begin
          pc_nxt    = '0;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: state_nxt = S_CHECK;
      S_CHECK: begin
        if (rdata == HALT_WORD) begin
          state_nxt = S_HALT;
        end else begin
          iin_nxt   = rdata;
          valid_nxt = 1'b1;
          timer_nxt = '0;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Completion wins over a timeout landing in the same cycle.
        if (instr_done) begin
          result_nxt = bus;
          valid_nxt  = 1'b0;
          if (pc == PC_LAST) begin
            state_nxt = S_HALT;
          end else begin
            pc_nxt    = pc + 1'b1;
            state_nxt = S_FETCH;
          end
        end else if (timer == T_LAST) begin
          valid_nxt = 1'b0;
          state_nxt = S_FAULT;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they change on the
  // same edge as the state and stay glitch-free.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      pc        <= '0;
      iin       <= '0;
      iin_valid <= 1'b0;
      result    <= '0;
      timer     <= '0;
      busy      <= 1'b0;
      halted    <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      iin       <= iin_nxt;
      iin_valid <= valid_nxt;
      result    <= result_nxt;
      timer     <= timer_nxt;
      busy      <= state_nxt inside {S_FETCH, S_CHECK, S_ISSUE};
      halted    <= (state_nxt == S_HALT);
      fault     <= (state_nxt == S_FAULT);
    end
  end

endmodule

// File: tb/tb_instr_feeder.sv
module tb_instr_feeder;
  localparam int AW = 6;
  localparam int DEPTH = 64;
  localparam int TO = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [15:0]   load_data = '0;
  logic          start = 1'b0;
  logic          instr_done = 1'b0;
  logic [15:0]   bus = '0;
  logic [15:0]   iin;
  logic          iin_valid;
  logic [AW-1:0] pc;
  logic [15:0]   result;
  logic          busy, halted, fault;

  instr_feeder #(.ADDR_W(AW), .HALT_WORD(16'hFFFF), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .instr_done(instr_done), .bus(bus),
    .iin(iin), .iin_valid(iin_valid), .pc(pc), .result(result),
    .busy(busy), .halted(halted), .fault(fault));

  always #5 clock = ~clock;

  typedef enum int {EV_ISSUE = 0, EV_HALT = 1, EV_FAULT = 2} ev_t;
  typedef struct {
    ev_t           kind;
    logic [15:0]   word;
    logic [AW-1:0] pc;
    logic [15:0]   res;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mdl_mem [DEPTH];
  logic [15:0] mdl_res = '0;
  int          plan_d [DEPTH];
  logic [15:0] plan_bus [DEPTH];
  bit          plan_poke [DEPTH];
  bit          plan_stray [DEPTH];
  int          n_iss;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void push_ev(input ev_t k, input logic [15:0] w,
                                  input logic [AW-1:0] p, input logic [15:0] r);
    exp_t e;
    e.kind = k; e.word = w; e.pc = p; e.res = r;
    exp_q.push_back(e);
  endfunction

  // Reference model: walk the program as the processor sees it.
  function automatic void build_expect(input int abort_k);
    logic [AW-1:0] p = '0;
    logic [15:0]   r = mdl_res;
    n_iss = 0;
    for (int g = 0; g <= DEPTH; g++) begin
      if (mdl_mem[p] == 16'hFFFF) begin push_ev(EV_HALT, 16'h0, p, r); break; end
      push_ev(EV_ISSUE, mdl_mem[p], p, 16'h0);
      n_iss++;
      if (n_iss - 1 == abort_k) break;
      if (plan_d[n_iss-1] >= TO) begin push_ev(EV_FAULT, 16'h0, p, r); break; end
      r = plan_bus[n_iss-1];
      if (int'(p) == DEPTH - 1) begin push_ev(EV_HALT, 16'h0, p, r); break; end
      p = p + 1'b1;
    end
    mdl_res = r;
  endfunction

  function automatic void reset_plan();
    for (int i = 0; i < DEPTH; i++) begin
      plan_d[i]     = $urandom_range(0, TO - 1);
      plan_bus[i]   = 16'($urandom);
      plan_poke[i]  = 1'b0;
      plan_stray[i] = 1'b0;
    end
  endfunction

  // Monitor: pops the scoreboard on every DUT-visible event.
  int anchor = 0, rise = 0;
  bit p_busy = 0, p_valid = 0, p_halted = 0, p_fault = 0;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (busy && !p_busy) anchor = cyc;
      if (!iin_valid && p_valid) anchor = cyc;
      if ((iin_valid && !p_valid) || (halted && !p_halted) || (fault && !p_fault)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", 32'(halted) | (32'(fault) << 1) | (32'(iin_valid) << 2), 32'h0);
        end else begin
          e = exp_q.pop_front();
          if (iin_valid && !p_valid) begin
            rise = cyc;
            chk("event_kind", EV_ISSUE, e.kind);
            chk("iin", iin, e.word);
            chk("issue_pc", pc, e.pc);
            chk("valid_latency", cyc - anchor, 2);
          end else if (halted) begin
            chk("event_kind", EV_HALT, e.kind);
            chk("halt_pc", pc, e.pc);
            chk("halt_result", result, e.res);
            chk("halt_valid", iin_valid, 0);
          end else begin
            chk("event_kind", EV_FAULT, e.kind);
            chk("fault_pc", pc, e.pc);
            chk("fault_result", result, e.res);
            chk("fault_valid", iin_valid, 0);
            chk("fault_latency", cyc - rise, TO);
          end
        end
      end
    end
    p_busy = busy; p_valid = iin_valid; p_halted = halted; p_fault = fault;
  end

  task automatic check_reset_outs();
    chk("rst_iin", iin, 0);
    chk("rst_valid", iin_valid, 0);
    chk("rst_pc", pc, 0);
    chk("rst_result", result, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fault", fault, 0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    mdl_res = '0;
    check_reset_outs();
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [15:0] d);
    @(negedge clock);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clock);
    load_en = 1'b0;
    mdl_mem[a] = d;
  endtask

  task automatic wait_valid(output bit ok);
    int c = 0;
    while (!iin_valid && c < 30) begin @(negedge clock); c++; end
    ok = iin_valid;
    chk("wait_valid", 32'(ok), 1);
  endtask

  task automatic wait_end();
    int c = 0;
    while (!(halted || fault) && c < 60) begin @(negedge clock); c++; end
    chk("run_end", 32'(halted | fault), 1);
    @(negedge clock);
    chk("queue_drain", exp_q.size(), 0);
  endtask

  task automatic run(input bit ld, input logic [15:0] ld0, input int abort_k);
    bit ok;
    if (ld) mdl_mem[0] = ld0;
    build_expect(abort_k);
    @(negedge clock);
    start = 1'b1;
    if (ld) begin load_en = 1'b1; load_addr = '0; load_data = ld0; end
    @(negedge clock);
    start = 1'b0; load_en = 1'b0;
    for (int k = 0; k < n_iss; k++) begin
      wait_valid(ok);
      if (!ok) break;
      if (k == abort_k) begin
        do_reset(1);
        return;
      end
      if (plan_d[k] >= TO) break;
      for (int j = 0; j < plan_d[k]; j++) begin
        @(negedge clock);
        if (plan_poke[k] && j == 0) begin
          start = 1'b1; load_en = 1'b1; load_addr = '0; load_data = 16'h0BAD;
        end else begin
          start = 1'b0; load_en = 1'b0;
        end
      end
      start = 1'b0; load_en = 1'b0;
      instr_done = 1'b1; bus = plan_bus[k];
      @(negedge clock);
      instr_done = 1'b0;
      if (plan_stray[k]) begin
        // lands while the next word is in CHECK
        @(negedge clock); instr_done = 1'b1;
        @(negedge clock); instr_done = 1'b0;
      end
    end
    wait_end();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    @(negedge clock);
    do_reset(2);

    // basic program, loaded before a reset to show memory survives it
    load(0, 16'h1234); load(1, 16'h2345); load(2, 16'hFFFF);
    do_reset(2);
    reset_plan();
    for (int i = 0; i < 3; i++) begin plan_d[i] = 3; plan_bus[i] = 16'hA000 + 16'(i); end
    run(0, 16'h0, -1);
    chk("basic_result", result, 16'hA001);

    // timeout, then restart with done on the last legal cycle
    reset_plan(); plan_d[0] = TO;
    run(0, 16'h0, -1);
    reset_plan(); plan_d[0] = TO - 1;
    run(0, 16'h0, -1);

    // ignored start/load during ISSUE and stray done in CHECK
    reset_plan(); plan_d[0] = 4; plan_poke[0] = 1'b1; plan_stray[0] = 1'b1;
    plan_stray[1] = 1'b1;
    run(0, 16'h0, -1);

    // load and start on the same edge
    reset_plan();
    run(1, 16'($urandom_range(0, 16'hFFFE)), -1);

    // mid-run reset then rerun of the intact program
    reset_plan();
    run(0, 16'h0, 1);
    reset_plan();
    run(0, 16'h0, -1);

    // random programs, occasionally timing out
    for (int t = 0; t < 6; t++) begin
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) load(AW'(i), 16'($urandom_range(0, 16'hFFFE)));
      load(AW'(len), 16'hFFFF);
      reset_plan();
      if ($urandom_range(0, 3) == 0) plan_d[$urandom_range(0, len - 1)] = TO + 2;
      run(0, 16'h0, -1);
    end

    // end of memory: every word is a real instruction
    for (int i = 0; i < DEPTH; i++) load(AW'(i), 16'($urandom_range(0, 16'hFFFE)));
    reset_plan();
    for (int i = 0; i < DEPTH; i++) plan_d[i] = $urandom_range(0, 3);
    run(0, 16'h0, -1);
    chk("eom_pc", pc, DEPTH - 1);
    chk("eom_halted", halted, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
